// File: rtl/mmio_button_conditioner.sv
// rtl/mmio_button_conditioner.sv - per-button sync, debounce, edge pulses and sticky press flags for the MMIO input word
`timescale 1ns/1ps

module mmio_button_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   clock,
  input  logic                   notReset,
  input  logic [NUM_BUTTONS-1:0] rawButton,
  input  logic [NUM_BUTTONS-1:0] clearSticky,
  output logic [NUM_BUTTONS-1:0] buttonLevel,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] releasePulse,
  output logic [NUM_BUTTONS-1:0] pressSticky,
  output logic [31:0]            mmioWord
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          REL_LEVEL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PEND_PRESS,
    ST_PRESSED,
    ST_PEND_RELEASE
  } state_e;

  logic [SYNC_STAGES-1:0] r_sync  [NUM_BUTTONS];
  state_e                 r_state [NUM_BUTTONS];
  logic [CW-1:0]          r_cnt   [NUM_BUTTONS];

  state_e                 w_state_nxt [NUM_BUTTONS];
  logic [CW-1:0]          w_cnt_nxt   [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_s;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_release;
  logic [NUM_BUTTONS-1:0] w_level_nxt;

  logic [NUM_BUTTONS-1:0] r_level;
  logic [NUM_BUTTONS-1:0] r_press;
  logic [NUM_BUTTONS-1:0] r_release;
  logic [NUM_BUTTONS-1:0] r_sticky;

  // Normalise polarity at the synchroniser output so the FSM always sees 1 = pressed.
  always_comb begin
    w_s = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_s[i] = r_sync[i][SYNC_STAGES-1] ^ REL_LEVEL;
    end
  end

  always_comb begin
    w_press     = '0;
    w_release   = '0;
    w_level_nxt = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_RELEASED: begin
          if (w_s[i]) begin
            w_state_nxt[i] = ST_PEND_PRESS;
            w_cnt_nxt[i]   = CNT_ONE;
          end else begin
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_PEND_PRESS: begin
          if (!w_s[i]) begin
            w_state_nxt[i] = ST_RELEASED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = '0;
            w_press[i]     = 1'b1;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!w_s[i]) begin
            w_state_nxt[i] = ST_PEND_RELEASE;
            w_cnt_nxt[i]   = CNT_ONE;
          end else begin
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_PEND_RELEASE: begin
          if (w_s[i]) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            w_state_nxt[i] = ST_RELEASED;
            w_cnt_nxt[i]   = '0;
            w_release[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_RELEASED;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_level_nxt[i] = (w_state_nxt[i] == ST_PRESSED) || (w_state_nxt[i] == ST_PEND_RELEASE);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!notReset) begin
        r_sync[i]  <= {SYNC_STAGES{REL_LEVEL}};
        r_state[i] <= ST_RELEASED;
        r_cnt[i]   <= '0;
      end else begin
        r_sync[i]  <= {r_sync[i][SYNC_STAGES-2:0], rawButton[i]};
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // A press accepted in the same cycle as a clear keeps the sticky bit set.
  always_ff @(posedge clock) begin
    if (!notReset) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_sticky  <= '0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_sticky  <= w_press | (r_sticky & ~clearSticky);
    end
  end

  assign buttonLevel  = r_level;
  assign pressPulse   = r_press;
  assign releasePulse = r_release;
  assign pressSticky  = r_sticky;

  always_comb begin
    mmioWord                   = '0;
    mmioWord[NUM_BUTTONS-1:0]  = r_level;
    mmioWord[8 +: NUM_BUTTONS] = r_sticky;
  end

endmodule

// File: tb/tb_mmio_button_conditioner.sv
// tb/tb_mmio_button_conditioner.sv - scoreboard bench for mmio_button_conditioner
`timescale 1ns/1ps

module tb_mmio_button_conditioner;

  localparam int LAT = 7;

  logic        clock;
  logic        notReset;
  logic [3:0]  rawButton;
  logic [3:0]  clearSticky;
  logic [3:0]  buttonLevel;
  logic [3:0]  pressPulse;
  logic [3:0]  releasePulse;
  logic [3:0]  pressSticky;
  logic [31:0] mmioWord;

  mmio_button_conditioner #(
    .NUM_BUTTONS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clock(clock),
    .notReset(notReset),
    .rawButton(rawButton),
    .clearSticky(clearSticky),
    .buttonLevel(buttonLevel),
    .pressPulse(pressPulse),
    .releasePulse(releasePulse),
    .pressSticky(pressSticky),
    .mmioWord(mmioWord)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] pp;
    logic [3:0] rp;
    logic [3:0] st;
    int         phase;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp;
  int         n_bad;
  int         phase;
  logic [3:0] e_lvl;
  logic [3:0] e_st;

  task automatic chk(input string nm, input int ph, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s phase=%0d t=%0t got=%h exp=%h", nm, ph, $time, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("buttonLevel",  e.phase, {28'd0, buttonLevel},  {28'd0, e.lvl});
        chk("pressPulse",   e.phase, {28'd0, pressPulse},   {28'd0, e.pp});
        chk("releasePulse", e.phase, {28'd0, releasePulse}, {28'd0, e.rp});
        chk("pressSticky",  e.phase, {28'd0, pressSticky},  {28'd0, e.st});
        chk("mmioWord",     e.phase, mmioWord, {20'd0, e.st, 4'd0, e.lvl});
      end
    end
  end

  task automatic step(input logic [3:0] p_raw, input logic [3:0] p_clr, input logic p_rstn,
                      input logic [3:0] p_pp, input logic [3:0] p_rp);
    exp_t e;
    @(negedge clock);
    rawButton   = p_raw;
    clearSticky = p_clr;
    notReset    = p_rstn;
    e.lvl   = e_lvl;
    e.pp    = p_pp;
    e.rp    = p_rp;
    e.st    = e_st;
    e.phase = phase;
    sb.push_back(e);
  endtask

  // Holds p_raw for n cycles; the LAT-th edge after the change accepts rise/fall.
  task automatic run(input logic [3:0] p_raw, input int n, input logic [3:0] rise,
                     input logic [3:0] fall, input logic [3:0] clr_lat);
    logic [3:0] pp;
    logic [3:0] rp;
    logic [3:0] clr;
    for (int k = 1; k <= n; k++) begin
      pp  = '0;
      rp  = '0;
      clr = '0;
      if (k == LAT) begin
        pp    = rise;
        rp    = fall;
        clr   = clr_lat;
        e_lvl = (e_lvl | rise) & ~fall;
        e_st  = rise | (e_st & ~clr);
      end
      step(p_raw, clr, 1'b1, pp, rp);
    end
  endtask

  task automatic clr_step(input logic [3:0] p_raw, input logic [3:0] clr);
    e_st = e_st & ~clr;
    step(p_raw, clr, 1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic rst_step(input logic [3:0] p_raw);
    e_lvl = '0;
    e_st  = '0;
    step(p_raw, 4'b0000, 1'b0, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [3:0] bounce [7];
    n_cmp       = 0;
    n_bad       = 0;
    phase       = 0;
    e_lvl       = '0;
    e_st        = '0;
    notReset    = 1'b0;
    rawButton   = 4'b0000;
    clearSticky = 4'b0000;
    bounce      = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1101, 4'b1101, 4'b1111};

    phase = 1;
    for (int i = 0; i < 3; i++) rst_step(4'b0000);
    run(4'b0000, 8, 4'b1111, 4'b0000, 4'b0000);
    run(4'b1111, 8, 4'b0000, 4'b1111, 4'b0000);
    clr_step(4'b1111, 4'b1111);

    phase = 2;
    run(4'b1110, 20, 4'b0001, 4'b0000, 4'b0000);
    run(4'b1111, 9, 4'b0000, 4'b0001, 4'b0000);

    phase = 3;
    for (int i = 0; i < 7; i++) run(bounce[i], 1, 4'b0000, 4'b0000, 4'b0000);
    run(4'b1111, 10, 4'b0000, 4'b0000, 4'b0000);

    phase = 4;
    run(4'b1011, 8, 4'b0100, 4'b0000, 4'b0000);
    clr_step(4'b1011, 4'b0100);
    run(4'b1011, 2, 4'b0000, 4'b0000, 4'b0000);

    phase = 5;
    run(4'b0011, 8, 4'b1000, 4'b0000, 4'b1000);
    clr_step(4'b0011, 4'b0010);
    run(4'b0011, 2, 4'b0000, 4'b0000, 4'b0000);
    run(4'b1111, 8, 4'b0000, 4'b1100, 4'b0000);

    phase = 6;
    run(4'b1110, 4, 4'b0000, 4'b0000, 4'b0000);
    rst_step(4'b1110);
    run(4'b1110, 10, 4'b0001, 4'b0000, 4'b0000);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clock);
    @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
